nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//   Sequential front-end for the 4-bit full-adder stage. Accepts a wide add request
//   (4*NIBBLES bits), feeds it one nibble per clock through a 4-bit carry-in/carry-out
//   adder slice, and registers the carry between cycles. It presents the assembled
//   sum and final carry with a one-cycle done pulse. It sits between the operand
//   source and result consumer and replaces a wide ripple adder with one 4-bit slice.
// PARAMETERS
//   NIBBLES   4   number of 4-bit slices; operand width W = 4*NIBBLES; must be >= 1
// PORTS
//   clk       in   1   system clock, all logic on rising edge
//   nrst      in   1   synchronous active-low reset
//   start     in   1   request valid; accepted when start && ready at a clk edge
//   ready     out  1   block can accept a request (state IDLE or DONE)
//   a_in      in   W   operand A, sampled only on the accepting edge
//   b_in      in   W   operand B, sampled only on the accepting edge
//   cin       in   1   carry-in to nibble 0, sampled only on the accepting edge
//   busy      out  1   high while in ADD
//   done      out  1   one-cycle pulse: sum_out/cout valid
//   sum_out   out  W   result (A + B + cin) mod 2^W, held until next accept
//   cout      out  1   carry out of the top nibble, held with sum_out
// BEHAVIOUR
//   - Reset (nrst low at edge): state=IDLE, ready=1, busy=0, done=0, sum_out=0,
//     cout=0, internal A/B shift regs, carry reg and nibble index all cleared. Reset
//     mid-ADD aborts the operation; no done pulse is produced for it.
//   - FSM states IDLE -> ADD -> DONE.
//     IDLE: ready=1. start at an edge: capture a_in, b_in, cin; idx=0; -> ADD.
//     ADD: each edge adds A[3:0] + B[3:0] + carry. The 4-bit result is written into
//       sum nibble idx. carry <= slice carry-out. A and B shift right by 4. idx++.
//       On the edge that processes idx==NIBBLES-1: cout <= carry-out; -> DONE.
//       start is ignored in ADD (ready=0); operand inputs may change freely.
//     DONE: done=1 for exactly this cycle; ready=1. start here is accepted
//       (back-to-back) -> ADD. Otherwise -> IDLE.
//   - Latency: done is high in the cycle after NIBBLES edges following the accepting
//     edge. Throughput: one result per NIBBLES+1 cycles.
//   - sum_out/cout are updated only at the final ADD edge. Partial nibbles are in an
//     internal register, so sum_out stays stable between done pulses.
//   - Arithmetic: unsigned, mod 2^W. Carry ripples across cycles exactly as a W-bit
//     adder would, e.g. all-ones + 1 propagates through every nibble.
//   - NIBBLES==1: a single ADD cycle, then DONE.
// CONFIGURATION
//   OVERFLOW_FLAG_EN defined: extra port ovf (out, 1) is registered with cout at the
//     final ADD edge. ovf = carry-into-MSB XOR carry-out-of-MSB (signed two's-
//     complement overflow). ovf resets to 0 and is held until the next result.
//   Undefined: no ovf port and no associated logic; other behaviour is identical.
// STRUCTURE
//   Package nibble_adder_pkg: typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
//     localparam int unsigned NIBBLE_W = 4.
//   Sub-module nibble_add: combinational 4-bit slice (a, b, cin -> s, cout). It is
//     instantiated once in the datapath.
//   The top level holds the FSM, the idx counter ($clog2(NIBBLES) bits, min 1), the
//     shift registers, the carry reg and the output regs.
// TESTING  (NIBBLES=4)
//   1. 0x1234 + 0x4321, cin=0 -> done 4 edges after accept; sum_out=0x5555, cout=0.
//   2. 0xFFFF + 0x0001, cin=0 -> sum_out=0x0000, cout=1 (carry through all 4 nibbles).
//   3. 0xFFFF + 0x0000, cin=1 -> sum_out=0x0000, cout=1; then start held in DONE with
//      0x0001+0x0001 -> accepted back-to-back, next done gives sum_out=0x0002.
//   4. start pulsed with 0xAAAA+0x5555 while busy -> ignored; the prior result still
//      completes and sum_out/cout unchanged by the ignored request.
//   5. nrst low for 1 cycle during the 2nd ADD cycle -> next cycle IDLE, ready=1,
//      sum_out=0, cout=0, and no done pulse.
//   6. OVERFLOW_FLAG_EN: 0x7FFF+0x0001 -> sum_out=0x8000, ovf=1, cout=0;
//      0xFFFF+0x0001 -> ovf=0, cout=1.

Source files
------------

// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit adder slice with carry in and carry out.
module nibble_add
    import nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that processes one nibble per clock through a single 4-bit slice.
// Optional signed-overflow output enabled by defining OVERFLOW_FLAG_EN.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
)
(
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        start,
    output logic                        ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a_in,
    input  logic [NIBBLE_W*NIBBLES-1:0] b_in,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum_out,
    output logic                        cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                        ovf
`endif
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state_reg, state_next;
    logic [W-1:0]       a_reg, b_reg;
    logic [W-1:0]       acc_reg, acc_next;
    logic [W-1:0]       sum_reg;
    logic               carry_reg;
    logic               cout_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [NIBBLE_W-1:0] slice_s;
    logic               slice_cout;
    logic               accept;
    logic               last_nibble;

    assign ready       = (state_reg == IDLE) || (state_reg == DONE);
    assign busy        = (state_reg == ADD);
    assign done        = (state_reg == DONE);
    assign accept      = start && ready;
    assign last_nibble = (idx_reg == IDX_W'(NIBBLES - 1));
    assign sum_out     = sum_reg;
    assign cout        = cout_reg;

    nibble_add u_slice (
        .a    (a_reg[NIBBLE_W-1:0]),
        .b    (b_reg[NIBBLE_W-1:0]),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Partial sum: only the nibble selected by idx takes the slice result.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign acc_next[gi*NIBBLE_W +: NIBBLE_W] =
            (idx_reg == IDX_W'(gi)) ? slice_s : acc_reg[gi*NIBBLE_W +: NIBBLE_W];
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (last_nibble) state_next = DONE;
            DONE:    state_next = start ? ADD : IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef OVERFLOW_FLAG_EN
    logic ovf_reg;
    logic msb_carry_in;

    // Carry into the top bit recovered from the slice's sum and operand bits.
    assign msb_carry_in = slice_s[NIBBLE_W-1] ^ a_reg[NIBBLE_W-1] ^ b_reg[NIBBLE_W-1];
    assign ovf          = ovf_reg;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == ADD && last_nibble) begin
            ovf_reg <= msb_carry_in ^ slice_cout;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx_reg   <= '0;
        end else if (accept) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            carry_reg <= cin;
            idx_reg   <= '0;
        end else if (state_reg == ADD) begin
            a_reg     <= a_reg >> NIBBLE_W;
            b_reg     <= b_reg >> NIBBLE_W;
            carry_reg <= slice_cout;
            acc_reg   <= acc_next;
            idx_reg   <= idx_reg + IDX_W'(1);
            if (last_nibble) begin
                sum_reg  <= acc_next;
                cout_reg <= slice_cout;
            end
        end
    end

endmodule
